ccip_mmio_csr_bank: RTL and testbench
=====================================

# ccip_mmio_csr_bank

Parametrised MMIO CSR bank that terminates CCI-P MMIO requests from the Rx C0 channel and returns read responses on Tx C2. It sits between the CCI-P boundary and AFU control logic. The block generalises the fixed single-register MMIO handling with:
- a configurable CSR count and base address;
- 4B/8B access with half-word selection;
- per-CSR read-only mapping;
- a configurable read latency;
- error accounting.

## Interface
Parameters:
- NUM_CSR, 16: number of 64-bit CSRs, 1..64.
- CSR_BASE, 16'h0020: 4B-granular MMIO address of CSR 0. CSR i occupies addresses CSR_BASE+2i (low half) and CSR_BASE+2i+1 (high half).
- RO_MASK, '0: NUM_CSR-bit mask. Bit i set means CSR i is read-only and reads return ro_in slice i.
- RD_LATENCY, 2: request-to-response cycles, 1..4.

Ports:
- clk  in  1  clock, single domain.
- SoftReset  in  1  asynchronous, active-high reset.
- rx  in  t_if_ccip_Rx  CCI-P Rx bus. C0Hdr is reinterpreted as t_ccip_Req_MmioHdr; both are 28 bits. Write data is C0Data[63:0].
- tx_c2_hdr  out  t_ccip_Rsp_MmioHdr  response tid.
- tx_c2_rdvalid  out  1  read response valid.
- tx_c2_data  out  64  read response data.
- csr_q  out  NUM_CSR*64  current value of the writable CSRs. Slice i = bits [64i+63:64i].
- csr_wr_pulse  out  NUM_CSR  one-cycle pulse in the cycle after CSR i is written.
- ro_in  in  NUM_CSR*64  hardware values for read-only CSRs.
- err_cnt  out  8  saturating count of dropped or erroneous requests.

## Operation
Decode:
- idx = (addr - CSR_BASE) >> 1.
- hit = addr >= CSR_BASE && idx < NUM_CSR. Compute the subtraction in 17 bits so an address below the base cannot wrap into a hit.

Writes (C0MmioWrValid):
- length 2'b01 (8B): requires addr[0]=0. All 64 bits are written.
- length 2'b00 (4B): addr[0]=0 writes bits [31:0] from data[31:0]; addr[0]=1 writes bits [63:32] from data[31:0].
- A write is dropped and err_cnt increments if any of these hold: miss, RO CSR, length 2'b10/2'b11, 8B write with addr[0]=1, or poison=1.

Reads (C0MmioRdValid):
- Every read gets exactly one response carrying the request tid, including erroneous ones.
- 8B read: returns the full CSR.
- 4B read: returns the selected half in [31:0], with [63:32]=0.
- Miss, bad length, misaligned 8B read, or poison returns 64'h0 and increments err_cnt.
- RO CSRs return the ro_in slice sampled in the request cycle.

Simultaneous events:
- If C0MmioWrValid and C0MmioRdValid are asserted in the same cycle (a protocol violation), the write is performed. The read is dropped with no response, and err_cnt increments by 1.
- C0RdValid, C0WrValid and C0UMsgValid are ignored.

err_cnt saturates at 8'hFF.

## Timing
- Request sampled at rising edge k. A write updates csr_q at edge k, and csr_wr_pulse is high in cycle k+1.
- Read: response data is captured at edge k from the pre-write register state. tx_c2_rdvalid is high for exactly one cycle, RD_LATENCY cycles after the request cycle.
- Back-to-back reads produce back-to-back responses in order. There is no backpressure on C2.
- Write to CSR i at cycle k, then read of CSR i at cycle k+1: the read returns the new value.
- Reset: all outputs and CSRs are 0. tx_c2_hdr and tx_c2_data are 0 whenever rdvalid is 0.
- Asserting SoftReset mid-operation flushes in-flight read responses; they are never delivered. The first response after deassertion can only come from a request sampled after deassertion.

## Structure
- Add to the shared CCI-P package:
  - typedef enum t_ccip_mmio_len: eMMIO_4B=2'b00, eMMIO_8B=2'b01, eMMIO_64B=2'b10.
  - CCIP_MMIO_TID_WIDTH=9.
- Sub-module ccip_mmio_rd_pipe: parametrised RD_LATENCY-deep shift register of {valid, tid, data} with asynchronous reset clearing all valids.

## Test plan
- 8B write 64'hDEAD_BEEF_0123_4567 to addr 16'h0022 (CSR 1), then 8B read with tid 9'h05:
  - csr_q slice 1 updates;
  - csr_wr_pulse[1] pulses once;
  - response has tid 9'h05 and the same data exactly RD_LATENCY cycles after the read.
- 4B write 32'hAAAA_5555 to 16'h0023, then 4B read of 16'h0023:
  - CSR 1 becomes 64'hAAAA_5555_0123_4567;
  - the read returns 64'h0000_0000_AAAA_5555.
- Reads of address 16'h001E, address CSR_BASE+2*NUM_CSR, and an 8B read of an odd address:
  - each returns data 0 with the correct tid;
  - err_cnt increments by 3.
- RO_MASK bit 2 set, ro_in slice 2 = 64'h1234:
  - a write to 16'h0024 is dropped and err_cnt increments;
  - a read returns 64'h1234.
- Four back-to-back reads with tids 1..4, with SoftReset asserted in the cycle after the 2nd read:
  - no response is ever delivered;
  - csr_q and err_cnt are 0 after reset.
- 300 poisoned writes: err_cnt saturates at 8'hFF and no CSR changes.

Source files
------------

// File: rtl/ccip_if_pkg.sv
// rtl/ccip_if_pkg.sv - shared CCI-P types: MMIO request/response headers, Rx bus, MMIO length encoding
package ccip_if_pkg;

  localparam int CCIP_MMIO_ADDR_WIDTH = 16;
  localparam int CCIP_MMIO_TID_WIDTH  = 9;
  localparam int CCIP_CLDATA_WIDTH    = 512;

  typedef logic [CCIP_MMIO_ADDR_WIDTH-1:0] t_ccip_mmioAddr;
  typedef logic [CCIP_MMIO_TID_WIDTH-1:0]  t_ccip_tid;

  typedef enum logic [1:0] {
    eMMIO_4B  = 2'b00,
    eMMIO_8B  = 2'b01,
    eMMIO_64B = 2'b10
  } t_ccip_mmio_len;

  // 28 bits, overlays C0Hdr; the spare header bit carries poison
  typedef struct packed {
    t_ccip_mmioAddr address;
    t_ccip_mmio_len length;
    logic           poison;
    t_ccip_tid      tid;
  } t_ccip_Req_MmioHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_Rsp_MmioHdr;

  typedef struct packed {
    logic [27:0]                  C0Hdr;
    logic [CCIP_CLDATA_WIDTH-1:0] C0Data;
    logic                         C0WrValid;
    logic                         C0RdValid;
    logic                         C0UMsgValid;
    logic                         C0MmioRdValid;
    logic                         C0MmioWrValid;
  } t_if_ccip_Rx;

  function automatic logic mmio_len_ok(t_ccip_mmio_len len, logic odd);
    return (len == eMMIO_4B) || ((len == eMMIO_8B) && !odd);
  endfunction

endpackage

// File: rtl/ccip_mmio_rd_pipe.sv
// rtl/ccip_mmio_rd_pipe.sv - fixed-latency shift register for MMIO read responses
module ccip_mmio_rd_pipe #(
  parameter int RD_LATENCY = 2,
  parameter int TID_W      = 9,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [TID_W-1:0]  tid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [TID_W-1:0]  tid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [RD_LATENCY-1:0]             valid_q;
  logic [RD_LATENCY-1:0][TID_W-1:0]  tid_q;
  logic [RD_LATENCY-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tid_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      tid_q[0]   <= tid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        tid_q[i]   <= tid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LATENCY-1];
  assign tid_o   = tid_q[RD_LATENCY-1];
  assign data_o  = data_q[RD_LATENCY-1];

endmodule

// File: rtl/ccip_mmio_csr_bank.sv
// rtl/ccip_mmio_csr_bank.sv - CCI-P MMIO CSR bank: decodes C0 MMIO requests, answers reads on C2
module ccip_mmio_csr_bank
  import ccip_if_pkg::*;
#(
  parameter int                 NUM_CSR    = 16,
  parameter logic [15:0]        CSR_BASE   = 16'h0020,
  parameter logic [NUM_CSR-1:0] RO_MASK    = '0,
  parameter int                 RD_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     SoftReset,
  input  t_if_ccip_Rx              rx,
  output t_ccip_Rsp_MmioHdr        tx_c2_hdr,
  output logic                     tx_c2_rdvalid,
  output logic [63:0]              tx_c2_data,
  output logic [NUM_CSR*64-1:0]    csr_q,
  output logic [NUM_CSR-1:0]       csr_wr_pulse,
  input  logic [NUM_CSR*64-1:0]    ro_in,
  output logic [7:0]               err_cnt
);

  localparam int IDXW = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;

  t_ccip_Req_MmioHdr             hdr;
  logic [16:0]                   offset;
  logic                          hit, is_ro, len_ok, wr, rd, wr_ok, rd_ok, rd_issue;
  logic [IDXW-1:0]               sel;
  logic [NUM_CSR-1:0][63:0]      csrs_q, csrs_d, ro_arr;
  logic [NUM_CSR-1:0]            pulse_q, pulse_d;
  logic [7:0]                    err_q, err_d;
  logic [1:0]                    err_inc;
  logic [8:0]                    err_sum;
  logic [63:0]                   rd_word, rd_data;
  logic                          unused_rx;

  assign hdr    = t_ccip_Req_MmioHdr'(rx.C0Hdr);
  assign ro_arr = ro_in;

  // 17-bit offset: a borrow out of bit 16 marks an address below the base
  assign offset = {1'b0, hdr.address} - {1'b0, CSR_BASE};
  assign hit    = !offset[16] && (offset[15:1] < 15'(NUM_CSR));
  assign sel    = offset[IDXW:1];
  assign is_ro  = RO_MASK[sel];
  assign len_ok = mmio_len_ok(hdr.length, hdr.address[0]);

  assign wr       = rx.C0MmioWrValid;
  assign rd       = rx.C0MmioRdValid;
  assign wr_ok    = wr && hit && !is_ro && len_ok && !hdr.poison;
  assign rd_ok    = hit && len_ok && !hdr.poison;
  assign rd_issue = rd && !wr;

  always_comb begin
    csrs_d  = csrs_q;
    pulse_d = '0;
    if (wr_ok) begin
      pulse_d[sel] = 1'b1;
      if (hdr.length == eMMIO_8B) csrs_d[sel] = rx.C0Data[63:0];
      else if (hdr.address[0])    csrs_d[sel][63:32] = rx.C0Data[31:0];
      else                        csrs_d[sel][31:0]  = rx.C0Data[31:0];
    end
  end

  assign rd_word = is_ro ? ro_arr[sel] : csrs_q[sel];

  always_comb begin
    rd_data = '0;
    if (rd_issue && rd_ok) begin
      if (hdr.length == eMMIO_8B) rd_data = rd_word;
      else rd_data = {32'h0, hdr.address[0] ? rd_word[63:32] : rd_word[31:0]};
    end
  end

  // a colliding read is dropped and counted once, independent of the write's own status
  assign err_inc = {1'b0, wr && !wr_ok} + {1'b0, rd && wr} + {1'b0, rd_issue && !rd_ok};
  assign err_sum = {1'b0, err_q} + {7'b0, err_inc};
  assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      csrs_q  <= '0;
      pulse_q <= '0;
      err_q   <= '0;
    end else begin
      csrs_q  <= csrs_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  ccip_mmio_rd_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .TID_W      (CCIP_MMIO_TID_WIDTH),
    .DATA_W     (64)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (SoftReset),
    .valid_i (rd_issue),
    .tid_i   (rd_issue ? hdr.tid : '0),
    .data_i  (rd_data),
    .valid_o (tx_c2_rdvalid),
    .tid_o   (tx_c2_hdr.tid),
    .data_o  (tx_c2_data)
  );

  assign csr_q        = csrs_q;
  assign csr_wr_pulse = pulse_q;
  assign err_cnt      = err_q;

  assign unused_rx = ^{rx.C0Data[CCIP_CLDATA_WIDTH-1:64], rx.C0RdValid, rx.C0WrValid,
                       rx.C0UMsgValid, offset[0]};

endmodule

// File: tb/tb_ccip_mmio_csr_bank.sv
// tb/tb_ccip_mmio_csr_bank.sv - scoreboard bench for the MMIO CSR bank
module tb_ccip_mmio_csr_bank;
  import ccip_if_pkg::*;

  localparam int          NUM_CSR  = 16;
  localparam logic [15:0] CSR_BASE = 16'h0020;
  localparam logic [15:0] RO_MASK  = 16'h0004;
  localparam int          RD_LAT   = 2;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      SoftReset = 1'b1;
  t_if_ccip_Rx               rx;
  t_ccip_Rsp_MmioHdr         tx_c2_hdr;
  logic                      tx_c2_rdvalid;
  logic [63:0]               tx_c2_data;
  logic [NUM_CSR*64-1:0]     csr_q;
  logic [NUM_CSR-1:0]        csr_wr_pulse;
  logic [NUM_CSR*64-1:0]     ro_in;
  logic [7:0]                err_cnt;

  exp_t               sb[$];
  logic [63:0]        m_csr[NUM_CSR];
  int                 m_err;
  logic [NUM_CSR-1:0] m_pulse;
  int                 checks = 0;
  int                 errors = 0;
  int                 cyc = 0;
  bit                 rand_ro = 0;

  ccip_mmio_csr_bank #(
    .NUM_CSR    (NUM_CSR),
    .CSR_BASE   (CSR_BASE),
    .RO_MASK    (RO_MASK),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk           (clk),
    .SoftReset     (SoftReset),
    .rx            (rx),
    .tx_c2_hdr     (tx_c2_hdr),
    .tx_c2_rdvalid (tx_c2_rdvalid),
    .tx_c2_data    (tx_c2_data),
    .csr_q         (csr_q),
    .csr_wr_pulse  (csr_wr_pulse),
    .ro_in         (ro_in),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit model_decode(input logic [15:0] addr, output int idx);
    int a = int'(addr);
    idx = 0;
    if (a < int'(CSR_BASE)) return 0;
    idx = (a - int'(CSR_BASE)) / 2;
    return idx < NUM_CSR;
  endfunction

  task automatic model_reset();
    foreach (m_csr[i]) m_csr[i] = 64'h0;
    m_err   = 0;
    m_pulse = '0;
    sb.delete();
  endtask

  // One clock of stimulus: drive just after the edge, predict, then retire the model at the next edge
  task automatic cycle(input bit rst, input bit wr, input bit rd, input logic [15:0] addr,
                       input logic [1:0] len, input bit poison, input logic [8:0] tid,
                       input logic [63:0] data);
    t_ccip_Req_MmioHdr h;
    int idx, inc;
    bit hit, ok, wok;
    logic [63:0] word, rexp;
    exp_t e;
    #1;
    SoftReset = rst;
    if (rst) model_reset();
    if (rand_ro) ro_in[2*64 +: 64] = {$urandom(), $urandom()};
    h.address = addr;
    h.length  = t_ccip_mmio_len'(len);
    h.poison  = poison;
    h.tid     = tid;
    rx.C0Hdr         = h;
    rx.C0Data        = {{14{$urandom()}}, data};
    rx.C0MmioWrValid = wr;
    rx.C0MmioRdValid = rd;
    rx.C0RdValid     = 1'($urandom());
    rx.C0WrValid     = 1'($urandom());
    rx.C0UMsgValid   = 1'($urandom());
    hit = model_decode(addr, idx);
    ok  = hit && !poison && ((len == 2'b00) || (len == 2'b01 && !addr[0]));
    wok = wr && ok && !RO_MASK[idx];
    inc = 0;
    if (rd && !wr) begin
      word = 64'h0;
      if (hit) word = RO_MASK[idx] ? ro_in[idx*64 +: 64] : m_csr[idx];
      if (!ok)             rexp = 64'h0;
      else if (len == 2'b01) rexp = word;
      else                 rexp = {32'h0, addr[0] ? word[63:32] : word[31:0]};
      if (!ok) inc++;
      if (!rst) begin
        e.tid = tid; e.data = rexp; e.cyc = cyc + RD_LAT;
        sb.push_back(e);
      end
    end
    if (rd && wr) inc++;
    if (wr && !wok) inc++;
    @(posedge clk);
    if (!rst) begin
      m_pulse = '0;
      if (wok) begin
        m_pulse[idx] = 1'b1;
        if (len == 2'b01)  m_csr[idx] = data;
        else if (addr[0])  m_csr[idx][63:32] = data[31:0];
        else               m_csr[idx][31:0] = data[31:0];
      end
      m_err = (m_err + inc > 255) ? 255 : m_err + inc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'h0, 2'b00, 0, 9'h0, 64'h0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int bad;
    bad = -1;
    for (int i = 0; i < NUM_CSR; i++)
      if (bad < 0 && csr_q[i*64 +: 64] !== m_csr[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL csr_q slice %0d: got %h expected %h (cycle %0d)",
               bad, csr_q[bad*64 +: 64], m_csr[bad], cyc);
    end
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
    chk("csr_wr_pulse", 64'(csr_wr_pulse), 64'(m_pulse));
    if (tx_c2_rdvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got tid %h data %h expected no response (cycle %0d)",
                 tx_c2_hdr.tid, tx_c2_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_tid", 64'(tx_c2_hdr.tid), 64'(e.tid));
        chk("rsp_data", tx_c2_data, e.data);
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      chk("idle_hdr_data", {tx_c2_data[54:0], tx_c2_hdr.tid}, 64'h0);
    end
  end

  initial begin
    rx    = '0;
    ro_in = '0;
    for (int i = 0; i < NUM_CSR; i++) ro_in[i*64 +: 64] = {$urandom(), $urandom()};
    ro_in[2*64 +: 64] = 64'h1234;
    model_reset();
    repeat (3) @(posedge clk);
    cycle(1, 0, 0, 16'h0, 2'b00, 0, 9'h0, 64'h0);
    idle(2);

    cycle(0, 1, 0, 16'h0022, 2'b01, 0, 9'h0, 64'hDEAD_BEEF_0123_4567);
    cycle(0, 0, 1, 16'h0022, 2'b01, 0, 9'h005, 64'h0);
    idle(3);
    cycle(0, 1, 0, 16'h0023, 2'b00, 0, 9'h0, 64'h0000_0000_AAAA_5555);
    cycle(0, 0, 1, 16'h0023, 2'b00, 0, 9'h006, 64'h0);
    idle(3);
    chk("csr1_after_4b", csr_q[64 +: 64], 64'hAAAA_5555_0123_4567);

    cycle(0, 0, 1, 16'h001E, 2'b01, 0, 9'h007, 64'h0);
    cycle(0, 0, 1, CSR_BASE + 16'(2 * NUM_CSR), 2'b01, 0, 9'h008, 64'h0);
    cycle(0, 0, 1, 16'h0021, 2'b01, 0, 9'h009, 64'h0);
    idle(3);
    chk("err_after_misses", 64'(err_cnt), 64'd3);

    cycle(0, 1, 0, 16'h0024, 2'b01, 0, 9'h0, 64'hFFFF_0000_FFFF_0000);
    cycle(0, 0, 1, 16'h0024, 2'b01, 0, 9'h00A, 64'h0);
    cycle(0, 1, 1, 16'h0026, 2'b01, 0, 9'h00B, 64'h0BAD_CAFE_0000_0003);
    idle(4);

    cycle(0, 0, 1, 16'h0022, 2'b01, 0, 9'h001, 64'h0);
    cycle(0, 0, 1, 16'h0022, 2'b01, 0, 9'h002, 64'h0);
    cycle(1, 0, 1, 16'h0022, 2'b01, 0, 9'h003, 64'h0);
    cycle(1, 0, 1, 16'h0022, 2'b01, 0, 9'h004, 64'h0);
    cycle(0, 0, 0, 16'h0, 2'b00, 0, 9'h0, 64'h0);
    idle(5);

    for (int i = 0; i < 300; i++)
      cycle(0, 1, 0, 16'h001C + 16'($urandom_range(0, 40)), 2'($urandom_range(0, 1)), 1,
            9'h0, {$urandom(), $urandom()});
    idle(1);
    chk("err_saturated", 64'(err_cnt), 64'hFF);

    cycle(1, 0, 0, 16'h0, 2'b00, 0, 9'h0, 64'h0);
    rand_ro = 1;
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [1:0] len;
      op  = $urandom_range(0, 3);
      len = ($urandom_range(0, 7) < 6) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      cycle(0, op == 1, op >= 2, 16'h001C + 16'($urandom_range(0, 40)), len,
            $urandom_range(0, 15) == 0, 9'($urandom()), {$urandom(), $urandom()});
    end
    idle(RD_LAT + 3);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
